// File: rtl/fetch_decode_execute_pkg.sv
// Shared RV32I opcode/funct constants, ALU op encoding and the decoded-instruction record
// used by the fetch/decode/execute step engine.
package fetch_decode_execute_pkg;

  localparam logic [6:0] OpcLui    = 7'h37;
  localparam logic [6:0] OpcAuipc  = 7'h17;
  localparam logic [6:0] OpcJal    = 7'h6F;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcLoad   = 7'h03;
  localparam logic [6:0] OpcStore  = 7'h23;
  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcOp     = 7'h33;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        is_lui;
    logic        is_auipc;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_alu;     // OP or OP-IMM
    logic        is_op;      // register-register form; selects rs2 as ALU operand b
    logic        writes;     // writes rd (before the rd != 0 qualification)
    logic        illegal;
  } decoded_t;

  // bit30 distinguishes sub/sra; subtraction only exists in the register-register form.
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic bit30, input logic is_op);
    alu_op_e op;
    case (f3)
      F3AddSub: op = (is_op && bit30) ? AluSub : AluAdd;
      F3Sll:    op = AluSll;
      F3Slt:    op = AluSlt;
      F3Sltu:   op = AluSltu;
      F3Xor:    op = AluXor;
      F3SrlSra: op = bit30 ? AluSra : AluSrl;
      F3Or:     op = AluOr;
      default:  op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t d;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    d        = '0;
    d.rd     = instr[11:7];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct3 = instr[14:12];
    d.alu_op = AluAdd;
    case (instr[6:0])
      OpcLui:    begin d.is_lui    = 1'b1; d.imm = imm_u; d.writes = 1'b1; end
      OpcAuipc:  begin d.is_auipc  = 1'b1; d.imm = imm_u; d.writes = 1'b1; end
      OpcJal:    begin d.is_jal    = 1'b1; d.imm = imm_j; d.writes = 1'b1; end
      OpcJalr:   begin d.is_jalr   = 1'b1; d.imm = imm_i; d.writes = 1'b1; end
      OpcBranch: begin d.is_branch = 1'b1; d.imm = imm_b; end
      OpcLoad:   begin d.is_load   = 1'b1; d.imm = imm_i; d.writes = 1'b1; end
      OpcStore:  begin d.is_store  = 1'b1; d.imm = imm_s; end
      OpcOpImm: begin
        d.is_alu = 1'b1;
        d.imm    = imm_i;
        d.writes = 1'b1;
        d.alu_op = alu_sel(instr[14:12], instr[30], 1'b0);
      end
      OpcOp: begin
        d.is_alu = 1'b1;
        d.is_op  = 1'b1;
        d.writes = 1'b1;
        d.alu_op = alu_sel(instr[14:12], instr[30], 1'b1);
      end
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; shift amounts come from b[4:0].
module alu
  import fetch_decode_execute_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluSll:  y = a << b[4:0];
      AluSlt:  y = {31'b0, $signed(a) < $signed(b)};
      AluSltu: y = {31'b0, a < b};
      AluXor:  y = a ^ b;
      AluSrl:  y = a >> b[4:0];
      AluSra:  y = 32'($signed(a) >>> b[4:0]);
      AluOr:   y = a | b;
      AluAnd:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_execute.sv
// Single-issue RV32I step engine: one enabled pulse runs fetch, decode and execute of the
// instruction at pc and presents the registered results with completed held high.
module fetch_decode_execute
  import fetch_decode_execute_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic [31:0] pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        completed,
  output logic [31:0] pc_n,
  output logic [4:0]  rd,
  output logic        writes_to_reg,
  output logic        is_load,
  output logic        is_store,
  output logic [2:0]  funct3,
  output logic [31:0] store_data,
  output logic [31:0] result,
  output logic        is_jump_chosen,
  output logic [31:0] jump_dest,
  output logic        illegal
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StDone} state_e;

  state_e      state;
  logic [31:0] instr_q;
  decoded_t    dec;
  logic [31:0] alu_b, alu_y;
  logic [31:0] pc_imm;
  logic        taken;
  logic [31:0] result_d, jump_dest_d;
  logic        jump_d;

  assign dec = decode(instr_q);
  assign rs1 = dec.rs1;
  assign rs2 = dec.rs2;

  assign alu_b  = dec.is_op ? rs2_data : dec.imm;
  assign pc_imm = pc_n + dec.imm;

  alu u_alu (
    .op(dec.alu_op),
    .a (rs1_data),
    .b (alu_b),
    .y (alu_y)
  );

  always_comb begin
    taken = 1'b0;
    case (dec.funct3)
      F3Beq:   taken = (rs1_data == rs2_data);
      F3Bne:   taken = (rs1_data != rs2_data);
      F3Blt:   taken = ($signed(rs1_data) < $signed(rs2_data));
      F3Bge:   taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3Bltu:  taken = (rs1_data < rs2_data);
      F3Bgeu:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  // Illegal opcodes leave every flag clear, so they fall through to all-zero results.
  always_comb begin
    result_d    = '0;
    jump_d      = 1'b0;
    jump_dest_d = '0;
    if (dec.is_alu || dec.is_load || dec.is_store) result_d = alu_y;
    else if (dec.is_lui)                           result_d = dec.imm;
    else if (dec.is_auipc)                         result_d = pc_imm;
    else if (dec.is_jal || dec.is_jalr)            result_d = pc_n + 32'd4;
    if (dec.is_jal || (dec.is_branch && taken)) begin
      jump_d      = 1'b1;
      jump_dest_d = pc_imm;
    end else if (dec.is_jalr) begin
      jump_d      = 1'b1;
      jump_dest_d = alu_y & ~32'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state          <= StIdle;
      instr_q        <= '0;
      rom_addr       <= '0;
      pc_n           <= '0;
      completed      <= 1'b0;
      rd             <= '0;
      writes_to_reg  <= 1'b0;
      is_load        <= 1'b0;
      is_store       <= 1'b0;
      funct3         <= '0;
      store_data     <= '0;
      result         <= '0;
      is_jump_chosen <= 1'b0;
      jump_dest      <= '0;
      illegal        <= 1'b0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (enabled) begin
            state     <= StFetch;
            completed <= 1'b0;
            rom_addr  <= pc;
            pc_n      <= pc;
          end
        end
        // ROM answers one cycle after rom_addr, so this phase only waits for it.
        StFetch:  state <= StDecode;
        StDecode: begin
          instr_q <= rom_data;
          state   <= StExec;
        end
        StExec: begin
          rd             <= dec.rd;
          writes_to_reg  <= dec.writes && (dec.rd != 5'd0);
          is_load        <= dec.is_load;
          is_store       <= dec.is_store;
          funct3         <= dec.funct3;
          store_data     <= rs2_data;
          result         <= result_d;
          is_jump_chosen <= jump_d;
          jump_dest      <= jump_dest_d;
          illegal        <= dec.illegal;
          completed      <= 1'b1;
          state          <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed bench for fetch_decode_execute with a registered ROM model and a register file.
module tb_fetch_decode_execute;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enabled;
  logic [31:0] pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic        completed;
  logic [31:0] pc_n;
  logic [4:0]  rd;
  logic        writes_to_reg, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] store_data, result, jump_dest;
  logic        is_jump_chosen, illegal;

  logic [31:0] regs [32];
  logic [31:0] cur_pc, cur_instr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // One-cycle ROM holding a single word; any other address returns an illegal opcode.
  always @(posedge clk) rom_data <= (rom_addr == cur_pc) ? cur_instr : 32'h0000_007F;

  assign rs1_data = regs[rs1];
  assign rs2_data = regs[rs2];

  fetch_decode_execute dut (
    .clk           (clk),
    .rstn          (rstn),
    .enabled       (enabled),
    .pc            (pc),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .completed     (completed),
    .pc_n          (pc_n),
    .rd            (rd),
    .writes_to_reg (writes_to_reg),
    .is_load       (is_load),
    .is_store      (is_store),
    .funct3        (funct3),
    .store_data    (store_data),
    .result        (result),
    .is_jump_chosen(is_jump_chosen),
    .jump_dest     (jump_dest),
    .illegal       (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses enabled for one edge, then checks completed is low for two edges and high on the third.
  task automatic run_step(input logic [31:0] p, input logic [31:0] instr);
    @(negedge clk);
    pc        = p;
    cur_pc    = p;
    cur_instr = instr;
    enabled   = 1'b1;
    @(posedge clk); #1;
    enabled = 1'b0;
    check("completed_cleared", {31'b0, completed}, 32'd0);
    @(posedge clk); #1;
    check("completed_c1", {31'b0, completed}, 32'd0);
    @(posedge clk); #1;
    check("completed_c2", {31'b0, completed}, 32'd0);
    @(posedge clk); #1;
    check("completed_c3", {31'b0, completed}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rstn      = 1'b1;
    enabled   = 1'b0;
    pc        = 32'h0;
    cur_pc    = 32'hFFFF_FFFF;
    cur_instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_completed", {31'b0, completed}, 32'd0);
    check("rst_rom_addr", rom_addr, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_writes", {31'b0, writes_to_reg}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    rstn = 1'b0;

    // addi x1, x0, 5
    run_step(32'h10, 32'h0050_0093);
    check("addi_result", result, 32'd5);
    check("addi_rd", {27'b0, rd}, 32'd1);
    check("addi_writes", {31'b0, writes_to_reg}, 32'd1);
    check("addi_pc_n", pc_n, 32'h10);
    check("addi_rom_addr", rom_addr, 32'h10);
    check("addi_illegal", {31'b0, illegal}, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("addi_hold", {31'b0, completed}, 32'd1);

    // jal x1, +8
    run_step(32'h100, 32'h0080_00EF);
    check("jal_result", result, 32'h104);
    check("jal_jump", {31'b0, is_jump_chosen}, 32'd1);
    check("jal_dest", jump_dest, 32'h108);

    // beq x1, x2, -4: taken then not taken
    regs[1] = 32'd7;
    regs[2] = 32'd7;
    run_step(32'h20, 32'hFE20_8EE3);
    check("beq_t_jump", {31'b0, is_jump_chosen}, 32'd1);
    check("beq_t_dest", jump_dest, 32'h1C);
    check("beq_t_result", result, 32'd0);
    check("beq_t_writes", {31'b0, writes_to_reg}, 32'd0);
    regs[2] = 32'd8;
    run_step(32'h24, 32'hFE20_8EE3);
    check("beq_n_jump", {31'b0, is_jump_chosen}, 32'd0);
    check("beq_n_dest", jump_dest, 32'd0);

    // sw x2, 8(x1)
    regs[1] = 32'h1000;
    regs[2] = 32'hDEAD_BEEF;
    run_step(32'h30, 32'h0020_A423);
    check("sw_is_store", {31'b0, is_store}, 32'd1);
    check("sw_is_load", {31'b0, is_load}, 32'd0);
    check("sw_result", result, 32'h1008);
    check("sw_store_data", store_data, 32'hDEAD_BEEF);
    check("sw_writes", {31'b0, writes_to_reg}, 32'd0);
    check("sw_funct3", {29'b0, funct3}, 32'd2);

    // Reset one cycle into a step aborts it.
    @(negedge clk);
    pc        = 32'h40;
    cur_pc    = 32'h40;
    cur_instr = 32'h0050_0093;
    enabled   = 1'b1;
    @(posedge clk); #1;
    enabled = 1'b0;
    rstn    = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    check("abort_rom_addr", rom_addr, 32'd0);
    check("abort_result", result, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_completed", {31'b0, completed}, 32'd0);
    end
    run_step(32'h44, 32'h0050_0093);
    check("after_abort_result", result, 32'd5);
    check("after_abort_pc_n", pc_n, 32'h44);

    // Opcode 0x7F is illegal and behaves as a NOP.
    regs[31] = 32'h1234;
    run_step(32'h50, 32'hFFFF_FFFF);
    check("ill_illegal", {31'b0, illegal}, 32'd1);
    check("ill_writes", {31'b0, writes_to_reg}, 32'd0);
    check("ill_jump", {31'b0, is_jump_chosen}, 32'd0);
    check("ill_result", result, 32'd0);

    // sub x5, x3, x4
    regs[3] = 32'd5;
    regs[4] = 32'd7;
    run_step(32'h60, 32'h4041_82B3);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_rd", {27'b0, rd}, 32'd5);

    // sra x5, x3, x4 with only rs2[4:0] = 4 significant
    regs[3] = 32'h8000_0000;
    regs[4] = 32'h24;
    run_step(32'h64, 32'h4041_D2B3);
    check("sra_result", result, 32'hF800_0000);

    // sltu / slt x5, x3, x4 with -1 vs 1
    regs[3] = 32'hFFFF_FFFF;
    regs[4] = 32'd1;
    run_step(32'h68, 32'h0041_B2B3);
    check("sltu_result", result, 32'd0);
    run_step(32'h6C, 32'h0041_A2B3);
    check("slt_result", result, 32'd1);

    // lui x6, 0xABCDE
    run_step(32'h70, 32'hABCD_E337);
    check("lui_result", result, 32'hABCD_E000);
    check("lui_rd", {27'b0, rd}, 32'd6);
    check("lui_writes", {31'b0, writes_to_reg}, 32'd1);

    // addi x0, x0, 1 must not report a register write
    run_step(32'h74, 32'h0010_0013);
    check("x0_result", result, 32'd1);
    check("x0_writes", {31'b0, writes_to_reg}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_execute.md
FETCH_DECODE_EXECUTE -- requirements
Module: fetch_decode_execute

Interface
REQ-001 SHALL have ports: clk  in  1  clock; one clock domain, all logic on the rising edge.
REQ-002 SHALL have: rstn  in  1  reset; synchronous, active-high; name kept from the codebase convention.
REQ-003 SHALL have: enabled  in  1  start one step (sampled high for one cycle).
REQ-004 SHALL have: pc  in  32  address of the instruction.
REQ-005 SHALL have: rom_addr  out  32  ROM address; rom_data  in  32  ROM word, valid 1 cycle after rom_addr.
REQ-006 SHALL have: rs1, rs2  out  5  register-file read addresses; rs1_data, rs2_data  in  32  register values, combinational from rs1/rs2.
REQ-007 SHALL have: completed  out  1  step done (level).
REQ-008 SHALL have: pc_n  out  32  pc of the finished instruction.
REQ-009 SHALL have: rd  out  5; writes_to_reg  out  1; is_load, is_store  out  1; funct3  out  3; store_data  out  32 (rs2 value).
REQ-010 SHALL have: result  out  32; is_jump_chosen  out  1; jump_dest  out  32; illegal  out  1.

Function
REQ-011 SHALL run three phases: FETCH, DECODE, EXEC, then DONE. FETCH registers rom_addr<=pc and pc_n<=pc. DECODE captures rom_data and samples rs1_data/rs2_data. EXEC registers all outputs.
REQ-012 SHALL raise completed exactly 3 cycles after the enabled edge and hold it high until the next enabled.
REQ-013 SHALL clear completed on the cycle enabled is sampled; enabled while busy SHALL be ignored.
REQ-014 SHALL drive rs1=instr[19:15] and rs2=instr[24:20] combinationally from the captured instruction.
REQ-015 SHALL decode RV32I: LUI, AUIPC, JAL, JALR, BRANCH (6), LOAD, STORE, OP-IMM, OP. Sign-extend I/S/B/U/J immediates per the ISA.
REQ-016 SHALL compute result as follows:
- OP/OP-IMM: ALU (add, sub, sll, slt, sltu, xor, srl, sra, or, and); shifts use bits [4:0].
- LUI: imm.
- AUIPC: pc+imm.
- JAL/JALR: pc+4.
- LOAD/STORE: rs1+imm (address).
- BRANCH: 0.
REQ-017 SHALL set is_jump_chosen=1 for JAL, JALR and taken branches. jump_dest: JAL/branch = pc+imm; JALR = (rs1+imm)&~1. Not-taken branches SHALL give is_jump_chosen=0 and jump_dest=0.
REQ-018 SHALL set writes_to_reg=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM with rd!=0.
REQ-019 SHALL treat an unknown opcode as a NOP: illegal=1, writes_to_reg=0, is_jump_chosen=0, result=0.
REQ-020 SHALL wrap all arithmetic modulo 2^32; slt is signed, sltu is unsigned, sra is arithmetic.

Reset
REQ-021 When rstn is high on a clock edge, SHALL clear all outputs, return to idle, and set completed=0, rom_addr=0.
REQ-022 A reset mid-step SHALL abort the step; completed SHALL never rise for an aborted step.
REQ-023 When reset and enabled are high on the same edge, reset SHALL win.

Structure
REQ-024 Opcode/funct constants and a decoded-instruction struct (rd, rs1, rs2, imm, op flags) SHALL live in a shared package.
REQ-025 The ALU SHALL be one sub-module, alu (op, a, b -> y), combinational.

Verification
REQ-026 pc=0x10, rom_data=0x00500093 (addi x1,x0,5) -> completed at +3 cycles, result=5, rd=1, writes_to_reg=1, pc_n=0x10.
REQ-027 pc=0x100, JAL x1,+8 (0x008000EF) -> result=0x104, is_jump_chosen=1, jump_dest=0x108.
REQ-028 BEQ x1,x2 with rs1_data=rs2_data=7, imm=-4, pc=0x20 -> is_jump_chosen=1, jump_dest=0x1C. With rs2_data=8 -> is_jump_chosen=0.
REQ-029 SW with rs1_data=0x1000, imm=8, rs2_data=0xDEADBEEF -> is_store=1, result=0x1008, store_data=0xDEADBEEF, writes_to_reg=0.
REQ-030 rstn high one cycle after enabled -> completed stays 0; a new step afterward completes normally. Also: opcode 0x7F -> illegal=1.
